adau1761_i2s_port: RTL and testbench

Full-duplex I2S serial port between the AXI4-Lite register block of the ADAU1761 controller and the codec pins. It generates BCLK and LRCLK as bus master and serializes 24-bit left/right DAC samples from a 2-entry FIFO. It deserializes ADC data from the codec into 24-bit left/right words, and counts transmit underruns for status readback through the register file.

---
 rtl/adau1761_i2s_port_if.sv | 29 ++
 rtl/adau1761_i2s_port.sv | 155 +++++++++++++++
 tb/tb_adau1761_i2s_port.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/adau1761_i2s_port_if.sv
// Sample-stream and codec-pin bundle for the ADAU1761 I2S port.
// The port itself uses the slave modport; whatever feeds it uses master.
interface adau1761_i2s_port_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_left;
    logic [DATA_WIDTH-1:0] m_right;
    logic                  m_valid;
    logic [15:0]           underrun_cnt;
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata_out;
    logic                  sdata_in;

    modport master (
        output enable, s_left, s_right, s_valid, sdata_in,
        input  s_ready, m_left, m_right, m_valid, underrun_cnt, bclk, lrclk, sdata_out
    );

    modport slave (
        input  enable, s_left, s_right, s_valid, sdata_in,
        output s_ready, m_left, m_right, m_valid, underrun_cnt, bclk, lrclk, sdata_out
    );
endinterface

// File: rtl/adau1761_i2s_port.sv
// Full-duplex I2S bus master: 64-BCLK frames, 24-bit I2S-justified slots,
// 2-entry DAC FIFO, ADC deserializer and saturating underrun counter.
module adau1761_i2s_port #(
    parameter int unsigned HALF_DIV   = 16,
    parameter int unsigned DATA_WIDTH = 24
) (
    input logic               clock,
    input logic               reset,
    adau1761_i2s_port_if.slave bus
);
    localparam int unsigned DivW = $clog2(HALF_DIV);
    localparam int unsigned IdxW = $clog2(DATA_WIDTH);

    logic [DivW-1:0]       div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic [5:0]            bit_q, bit_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [DATA_WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic [DATA_WIDTH-1:0] m_l_q, m_l_d, m_r_q, m_r_d;
    logic                  m_valid_q, m_valid_d;
    logic [15:0]           underrun_q, underrun_d;

    logic [DATA_WIDTH-1:0] fifo_l_q [2];
    logic [DATA_WIDTH-1:0] fifo_r_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic tc, rise, fall, wrap, push, pop, s_ready;
    int unsigned           tx_slot, rx_slot;
    logic [IdxW-1:0]       tx_idx;

    assign tc      = (div_q == DivW'(HALF_DIV - 1));
    assign rise    = bus.enable & tc & ~bclk_q;
    assign fall    = bus.enable & tc & bclk_q;
    assign wrap    = fall & (bit_q == 6'd63);
    assign s_ready = (count_q != 2'd2);
    assign push    = bus.s_valid & s_ready;
    // Pop decision uses the pre-push count, so a same-cycle push never bypasses.
    assign pop     = wrap & (count_q != 2'd0);

    always_comb begin
        div_d      = div_q;
        bclk_d     = bclk_q;
        bit_d      = bit_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        rx_l_d     = rx_l_q;
        rx_r_d     = rx_r_q;
        m_l_d      = m_l_q;
        m_r_d      = m_r_q;
        m_valid_d  = 1'b0;
        underrun_d = underrun_q;
        tx_slot    = 0;
        rx_slot    = 0;
        tx_idx     = '0;
        if (!bus.enable) begin
            div_d   = '0;
            bclk_d  = 1'b0;
            bit_d   = '0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            tx_l_d  = '0;
            tx_r_d  = '0;
        end else begin
            div_d = tc ? '0 : div_q + 1'b1;
            if (tc) bclk_d = ~bclk_q;
            if (fall) begin
                bit_d   = bit_q + 6'd1;
                lrclk_d = bit_d[5];
                if (wrap) begin
                    tx_l_d = pop ? fifo_l_q[rd_ptr_q] : '0;
                    tx_r_d = pop ? fifo_r_q[rd_ptr_q] : '0;
                    if (!pop && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                end
                tx_slot = 32'(bit_d[4:0]);
                sdata_d = 1'b0;
                if (tx_slot >= 1 && tx_slot <= DATA_WIDTH) begin
                    tx_idx  = IdxW'(DATA_WIDTH - tx_slot);
                    sdata_d = bit_d[5] ? tx_r_q[tx_idx] : tx_l_q[tx_idx];
                end
            end
            if (rise) begin
                rx_slot = 32'(bit_q[4:0]);
                if (rx_slot >= 1 && rx_slot <= DATA_WIDTH) begin
                    if (bit_q[5]) rx_r_d = {rx_r_q[DATA_WIDTH-2:0], bus.sdata_in};
                    else          rx_l_d = {rx_l_q[DATA_WIDTH-2:0], bus.sdata_in};
                end
                if (bit_q == 6'(32 + DATA_WIDTH)) begin
                    m_l_d     = rx_l_q;
                    m_r_d     = {rx_r_q[DATA_WIDTH-2:0], bus.sdata_in};
                    m_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bit_q      <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
            m_l_q      <= '0;
            m_r_q      <= '0;
            m_valid_q  <= 1'b0;
            underrun_q <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_l_q[i] <= '0;
                fifo_r_q[i] <= '0;
            end
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_q      <= bit_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
            rx_l_q     <= rx_l_d;
            rx_r_q     <= rx_r_d;
            m_l_q      <= m_l_d;
            m_r_q      <= m_r_d;
            m_valid_q  <= m_valid_d;
            underrun_q <= underrun_d;
            if (push) begin
                fifo_l_q[wr_ptr_q] <= bus.s_left;
                fifo_r_q[wr_ptr_q] <= bus.s_right;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.m_left       = m_l_q;
    assign bus.m_right      = m_r_q;
    assign bus.m_valid      = m_valid_q;
    assign bus.underrun_cnt = underrun_q;
    assign bus.bclk         = bclk_q;
    assign bus.lrclk        = lrclk_q;
    assign bus.sdata_out    = sdata_q;
endmodule

// File: tb/tb_adau1761_i2s_port.sv
// Directed bench for adau1761_i2s_port at HALF_DIV=2 (256 clocks per frame).
module tb_adau1761_i2s_port;
    logic clk = 1'b0;
    logic rst;
    logic loopback = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic fell, lr_fell, bclk_prev = 1'b0, lr_prev = 1'b0;
    logic [63:0] got_frame, got_lr;
    int   n;
    logic seen;

    adau1761_i2s_port_if #(.DATA_WIDTH(24)) bus ();

    adau1761_i2s_port #(.HALF_DIV(2), .DATA_WIDTH(24)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    assign bus.sdata_in = loopback ? bus.sdata_out : 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
        fell      = bclk_prev & ~bus.bclk;
        lr_fell   = lr_prev & ~bus.lrclk;
        bclk_prev = bus.bclk;
        lr_prev   = bus.lrclk;
    endtask

    task automatic wait_lr_fall();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!lr_fell && k < 2000);
        if (!lr_fell) check("lr_fall_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_fall();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!fell && k < 100);
        if (!fell) check("bclk_fall_timeout", 64'd0, 64'd1);
    endtask

    // Captures bits 0..63 of the next loaded frame, bit 0 in the MSB position.
    task automatic capture_frame(output logic [63:0] data, output logic [63:0] lr);
        wait_lr_fall();
        data[63] = bus.sdata_out;
        lr[63]   = bus.lrclk;
        for (int k = 1; k < 64; k++) begin
            wait_fall();
            data[63-k] = bus.sdata_out;
            lr[63-k]   = bus.lrclk;
        end
    endtask

    task automatic push(input string tag, input logic [23:0] l, input logic [23:0] r);
        bus.s_left  = l;
        bus.s_right = r;
        bus.s_valid = 1'b1;
        check(tag, 64'(bus.s_ready), 64'd1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.s_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.s_left  = '0;
        bus.s_right = '0;
        bus.s_valid = 1'b0;
        bus.enable  = 1'b0;

        // Reset and idle
        do_reset();
        check("rst_bclk", 64'(bus.bclk), 64'd0);
        check("rst_lrclk", 64'(bus.lrclk), 64'd0);
        check("rst_sdata", 64'(bus.sdata_out), 64'd0);
        check("rst_mvalid", 64'(bus.m_valid), 64'd0);
        check("rst_mleft", 64'(bus.m_left), 64'd0);
        check("rst_mright", 64'(bus.m_right), 64'd0);
        check("rst_underrun", 64'(bus.underrun_cnt), 64'd0);
        check("rst_ready", 64'(bus.s_ready), 64'd1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= bus.bclk;
        end
        check("idle_bclk_static", 64'(seen), 64'd0);

        // TX pattern
        push("tx_push", 24'hA5F00F, 24'h3C0001);
        bus.enable = 1'b1;
        capture_frame(got_frame, got_lr);
        check("tx_frame", got_frame, frame_of(24'hA5F00F, 24'h3C0001));
        check("tx_lrclk", got_lr, {32'h0, 32'hFFFF_FFFF});
        check("tx_no_underrun", 64'(bus.underrun_cnt), 64'd0);

        // Loopback
        loopback = 1'b1;
        push("lb_push", 24'h123456, 24'h654321);
        n = 0;
        while (!bus.m_valid && n < 600) begin
            tick();
            n++;
        end
        check("lb_mvalid_seen", 64'(bus.m_valid), 64'd1);
        check("lb_mleft", 64'(bus.m_left), 64'h123456);
        check("lb_mright", 64'(bus.m_right), 64'h654321);
        tick();
        check("lb_mvalid_pulse", 64'(bus.m_valid), 64'd0);
        n = 0;
        repeat (256) begin
            tick();
            if (bus.m_valid) n++;
        end
        check("lb_pulses_per_frame", 64'(n), 64'd1);
        loopback = 1'b0;

        // FIFO full
        do_reset();
        push("full_push1", 24'h111111, 24'h222222);
        push("full_push2", 24'h333333, 24'h444444);
        bus.s_left  = 24'h555555;
        bus.s_right = 24'h666666;
        bus.s_valid = 1'b1;
        repeat (3) tick();
        check("full_ready_low", 64'(bus.s_ready), 64'd0);
        bus.enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.s_ready && n < 600);
        check("full_ready_at_load", 64'(lr_fell), 64'd1);
        tick();
        bus.s_valid = 1'b0;
        check("full_third_accepted", 64'(bus.s_ready), 64'd0);
        capture_frame(got_frame, got_lr);
        check("full_frame2", got_frame, frame_of(24'h333333, 24'h444444));
        capture_frame(got_frame, got_lr);
        check("full_frame3", got_frame, frame_of(24'h555555, 24'h666666));

        // Underrun and saturation
        do_reset();
        bus.enable = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            n = 0;
            do begin
                tick();
                seen |= bus.sdata_out;
                n++;
            end while (!lr_fell && n < 2000);
        end
        tick();
        check("underrun_5", 64'(bus.underrun_cnt), 64'd5);
        check("underrun_sdata_zero", 64'(seen), 64'd0);
        force dut.underrun_q = 16'hFFFE;
        tick();
        release dut.underrun_q;
        tick();
        check("underrun_preload", 64'(bus.underrun_cnt), 64'hFFFE);
        wait_lr_fall();
        wait_lr_fall();
        tick();
        check("underrun_saturate", 64'(bus.underrun_cnt), 64'hFFFF);

        // Reset mid-frame
        bus.enable = 1'b0;
        tick();
        push("mid_push1", 24'hABCDEF, 24'h012345);
        push("mid_push2", 24'hFEDCBA, 24'h543210);
        bus.enable = 1'b1;
        repeat (40) wait_fall();
        check("mid_lrclk_right", 64'(bus.lrclk), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_bclk", 64'(bus.bclk), 64'd0);
        check("mid_lrclk", 64'(bus.lrclk), 64'd0);
        check("mid_ready", 64'(bus.s_ready), 64'd1);
        check("mid_underrun", 64'(bus.underrun_cnt), 64'd0);
        rst = 1'b0;
        capture_frame(got_frame, got_lr);
        check("mid_flushed_frame", got_frame, 64'd0);
        tick();
        check("mid_flushed_underrun", 64'(bus.underrun_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
